serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. It time-shares one full-adder cell, built from two gate-level half adders plus an OR, across a WIDTH-bit operand pair.
- One bit is processed per clock, LSB first, under a small FSM. The block exposes a START/BUSY/DONE handshake to the requester.
- Used where area matters more than latency. It sits between a requester (register file or test controller) and the shared adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK    input   1      rising-edge clock
- RST    input   1      reset: synchronous, active-high
- START  input   1      request; sampled only in IDLE
- A      input   WIDTH  operand A, captured on the accepted START edge
- B      input   WIDTH  operand B, captured on the accepted START edge
- BUSY   output  1      high while state != IDLE
- DONE   output  1      one-cycle pulse; result valid
- SUM    output  WIDTH  result, held until next completion
- COUT   output  1      carry out of bit WIDTH-1, held with SUM

Behaviour:
- Clock/reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values: state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0. Internal shift registers, carry and bit counter are also cleared to 0.
- FSM states: IDLE, RUN, FIN.
- IDLE, START=0: stay in IDLE.
- IDLE, START=1 (on an edge):
  - A and B load into shift registers.
  - Internal carry C clears to 0 and bit counter CNT clears to 0.
  - Next state is RUN.
- RUN, each edge:
  - s = a0 ^ b0 ^ C.
  - C <= (a0&b0) | (C&(a0^b0)), i.e. two half adders plus an OR.
  - s shifts into the result register from the MSB side. A and B shift right by 1. CNT increments.
  - When CNT==WIDTH-1 on this edge:
    - SUM <= final result and COUT <= final carry.
    - Next state is FIN.
- FIN: DONE=1 for exactly this cycle. Next state is IDLE unconditionally.
- Latency: if START is accepted on edge k, FIN (DONE=1) is entered on edge k+WIDTH. DONE is visible for the cycle after edge k+WIDTH. Next start can be accepted at edge k+WIDTH+2.
- BUSY=1 in RUN and FIN; 0 only in IDLE.
- START while BUSY=1 is ignored; it does not queue and does not disturb the operation in flight.
- A and B are sampled only on the accepting edge. Later changes have no effect on the current operation.
- SUM and COUT change only on the edge that enters FIN. They hold their value otherwise, including through IDLE.
- Arithmetic is modulo 2^WIDTH; the carry beyond WIDTH appears only on COUT.
- RST asserted mid-operation: on that edge, state returns to IDLE and all outputs and internals return to their reset values. The partial result is discarded and no DONE is generated.
- RST and START high on the same edge: RST wins and START is dropped.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Extra input port SUB (1 bit), sampled with START.
  - When SUB=1 on the accepting edge, B is captured inverted and C initialises to 1, so the block computes A-B (two's complement).
  - COUT=1 means no borrow (A>=B unsigned).
  - SUB=0 behaves exactly as addition.
- Undefined: no SUB port; addition only. Logic is identical to the SUB=0 case.

Test Plan:
- Basic add: RST for 2 cycles, then START=1 for 1 cycle with A=8'h35, B=8'h4A.
  - Response: BUSY high the next cycle. DONE pulses 1 cycle exactly 8 edges after acceptance.
  - Result: SUM=8'h7F, COUT=0. BUSY drops the cycle after DONE.
- Carry out and hold: A=8'hFF, B=8'h01 gives SUM=8'h00, COUT=1. After DONE, SUM/COUT hold for 10+ idle cycles.
- Busy lockout:
  - Start A=8'h12, B=8'h34.
  - At RUN cycle 3, pulse START with A=8'hFF, B=8'hFF and change A/B.
  - Required: exactly one DONE, SUM=8'h46, COUT=0.
- Reset mid-operation:
  - Start A=8'h80, B=8'h80; assert RST at RUN cycle 4.
  - Required: no DONE; next cycle BUSY=0, SUM=0, COUT=0.
  - A new START with A=8'h01, B=8'h02 then gives SUM=8'h03.
- Back-to-back: START held high continuously. Operations are accepted every WIDTH+2 cycles, and each DONE shows the operands present at its accepting edge.
- Subtract (SERIAL_ADD_SUB_EN defined):
  - A=8'h10, B=8'h01, SUB=1 gives SUM=8'h0F, COUT=1.
  - A=8'h01, B=8'h02, SUB=1 gives SUM=8'hFF, COUT=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell (two half adders plus an OR), one bit per clock, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub input port, which makes the block compute a - b in two's complement.

module serial_add_half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    serial_add_half_adder u_ha0 (.x(a),  .y(b),  .s(s1), .c(c1));
    serial_add_half_adder u_ha1 (.x(s1), .y(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1: invert b at capture and seed the carry with 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub;
`else
    assign b_load = b;
    assign c_load = 1'b0;
`endif

    serial_add_full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_c)
    );

    assign res_nxt = {bit_s, res_sr[WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    carry  <= bit_c;
                    cnt    <= cnt + CNT_W'(1);
                    // The result registers only move on the edge that enters FIN.
                    if (cnt == LAST) begin
                        sum  <= res_nxt;
                        cout <= bit_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: scoreboard of expected sums/carries, checked when done pulses.
// Subtract steps are included when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } res_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub_i;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int   n_checks;
    int   n_fail;
    res_t sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub_i),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        logic [W:0] t;
        res_t r;
        if (sv) t = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
        else    t = {1'b0, av} + {1'b0, bv};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        return r;
    endfunction

    task automatic compare_result(input string tag);
        res_t e;
        check({tag, "_expected_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_sum"},  32'(sum),  32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
        end
    endtask

    // Drives one request from a negedge; optionally pulses a second start mid-run at glitch_at.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input int glitch_at);
        int lat;
        bit got;
        a     = av;
        b     = bv;
        sub_i = sv;
        start = 1'b1;
        sb.push_back(model(av, bv, sv));
        lat = 0;
        got = 0;
        while (!got && lat < 4 * W) begin
            @(negedge clk);
            lat++;
            if (done) got = 1;
            if (lat == 1) begin
                check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            if (glitch_at != 0 && lat == glitch_at) begin
                start = 1'b1;
                a     = '1;
                b     = '1;
            end
            if (glitch_at != 0 && lat == glitch_at + 1) begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_latency"}, 32'(lat - 1), 32'(W));
            check({tag, "_busy_in_fin"}, 32'(busy), 32'd1);
            compare_result(tag);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            check({tag, "_busy_drops"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        res_t last;
        int   n_done;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        sub_i    = 1'b0;
        a        = '0;
        b        = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add
        run_op("add_basic", 8'h35, 8'h4A, 1'b0, 0);

        // Carry out, then hold through idle while inputs wander
        run_op("add_carry", 8'hFF, 8'h01, 1'b0, 0);
        last = model(8'hFF, 8'h01, 1'b0);
        n_done = 0;
        repeat (12) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            if (done) n_done++;
            check("hold_sum",  32'(sum),  32'(last.sum));
            check("hold_cout", 32'(cout), 32'(last.cout));
        end
        check("hold_no_done", 32'(n_done), 32'd0);

        // Busy lockout: second start during RUN is ignored
        run_op("lockout", 8'h12, 8'h34, 1'b0, 3);
        n_done = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("lockout_no_second_done", 32'(n_done), 32'd0);
        check("lockout_idle", 32'(busy), 32'd0);

        // Reset mid-operation
        a     = 8'h80;
        b     = 8'h80;
        start = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) n_done++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum",  32'(sum),  32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        // Reset and start on the same edge: reset wins
        start = 1'b1;
        a     = 8'h05;
        b     = 8'h05;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_dropped", 32'(busy), 32'd0);
        repeat (W + 2) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        run_op("after_rst", 8'h01, 8'h02, 1'b0, 0);

        // Back-to-back with start held high: accept every W+2 edges
        n_done = 0;
        start  = 1'b1;
        for (int j = 0; j < 4 * (W + 2); j++) begin
            a = W'($urandom);
            b = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub_i = 1'($urandom);
`else
            sub_i = 1'b0;
`endif
            if (j % (W + 2) == 0) sb.push_back(model(a, b, sub_i));
            @(negedge clk);
            if (done) begin
                n_done++;
                compare_result("b2b");
            end
        end
        start = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                compare_result("b2b_tail");
            end
        end
        check("b2b_done_count", 32'(n_done), 32'd4);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        sub_i = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
        // Subtract mode
        run_op("sub_no_borrow", 8'h10, 8'h01, 1'b1, 0);
        run_op("sub_borrow",    8'h01, 8'h02, 1'b1, 0);
        run_op("sub0_is_add",   8'hC0, 8'h50, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
